// File: rtl/wdt_kick.sv
// Heartbeat (kick) generator for the watchdog interface.
// kick_out toggles every HALF_PERIOD slow ticks while the supervised logic
// keeps strobing `alive`. If the strobes stop for ALIVE_WINDOW ticks, the
// heartbeat freezes so the watchdog can trip. After a watchdog reset the
// block holds off for HOLDOFF ticks and then resumes.
module wdt_kick #(
    parameter logic [15:0] HALF_PERIOD  = 16'd20,
    parameter logic [15:0] ALIVE_WINDOW = 16'd100,
    parameter logic [15:0] HOLDOFF      = 16'd10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_1kHz,
    input  logic       enable,
    input  logic       alive,
    input  logic       wdt_reset_in,
    output logic       kick_out,
    output logic       fault,
    output logic [7:0] restart_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        STARVED = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        s1_q, s1_d;
    logic        s2_q, s2_d;
    logic        wdt_prev_q, wdt_prev_d;
    logic [15:0] half_cnt_q, half_cnt_d;
    logic [15:0] alive_cnt_q, alive_cnt_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic        kick_q, kick_d;
    logic        fault_q, fault_d;
    logic [7:0]  restart_q, restart_d;

    logic        tick;
    logic        wdt_rise;

    // The slow timebase is treated as data: one-clk pulse on its synchronised rising edge.
    assign tick     = s1_q & ~s2_q;
    assign wdt_rise = wdt_reset_in & ~wdt_prev_q;

    // Next-state and output logic, priority: enable low > watchdog reset edge > state behaviour.
    always_comb begin
        state_d     = state_q;
        s1_d        = clk_1kHz;
        s2_d        = s1_q;
        wdt_prev_d  = wdt_reset_in;
        half_cnt_d  = half_cnt_q;
        alive_cnt_d = alive_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        kick_d      = kick_q;
        fault_d     = fault_q;
        restart_d   = restart_q;

        if (!enable) begin
            state_d     = IDLE;
            kick_d      = 1'b0;
            fault_d     = 1'b0;
            half_cnt_d  = 16'd0;
            alive_cnt_d = 16'd0;
            hold_cnt_d  = 16'd0;
        end else if ((state_q != IDLE) && wdt_rise) begin
            // Watchdog fired (or fired again): restart the hold-off period.
            state_d     = HOLD;
            kick_d      = 1'b0;
            fault_d     = 1'b0;
            half_cnt_d  = 16'd0;
            alive_cnt_d = 16'd0;
            hold_cnt_d  = 16'd0;
            if (restart_q != 8'hFF) begin
                restart_d = restart_q + 8'd1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_d     = RUN;
                    half_cnt_d  = 16'd0;
                    alive_cnt_d = 16'd0;
                    hold_cnt_d  = 16'd0;
                end
                RUN: begin
                    if (tick && !alive && (alive_cnt_q == ALIVE_WINDOW - 16'd1)) begin
                        // Starvation wins over a same-tick toggle: heartbeat freezes as is.
                        state_d     = STARVED;
                        fault_d     = 1'b1;
                        half_cnt_d  = 16'd0;
                        alive_cnt_d = 16'd0;
                    end else begin
                        if (tick) begin
                            if (half_cnt_q == HALF_PERIOD - 16'd1) begin
                                kick_d     = ~kick_q;
                                half_cnt_d = 16'd0;
                            end else begin
                                half_cnt_d = half_cnt_q + 16'd1;
                            end
                        end
                        if (alive) begin
                            alive_cnt_d = 16'd0;
                        end else if (tick) begin
                            alive_cnt_d = alive_cnt_q + 16'd1;
                        end
                    end
                end
                STARVED: begin
                    half_cnt_d  = 16'd0;
                    alive_cnt_d = 16'd0;
                    if (alive) begin
                        state_d = RUN;
                        fault_d = 1'b0;
                    end
                end
                HOLD: begin
                    kick_d = 1'b0;
                    if (wdt_reset_in) begin
                        hold_cnt_d = 16'd0;
                    end else if (tick) begin
                        if (hold_cnt_q == HOLDOFF - 16'd1) begin
                            state_d     = RUN;
                            hold_cnt_d  = 16'd0;
                            half_cnt_d  = 16'd0;
                            alive_cnt_d = 16'd0;
                        end else begin
                            hold_cnt_d = hold_cnt_q + 16'd1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    kick_d  = 1'b0;
                    fault_d = 1'b0;
                end
            endcase
        end
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            wdt_prev_q  <= 1'b0;
            half_cnt_q  <= 16'd0;
            alive_cnt_q <= 16'd0;
            hold_cnt_q  <= 16'd0;
            kick_q      <= 1'b0;
            fault_q     <= 1'b0;
            restart_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            wdt_prev_q  <= wdt_prev_d;
            half_cnt_q  <= half_cnt_d;
            alive_cnt_q <= alive_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            kick_q      <= kick_d;
            fault_q     <= fault_d;
            restart_q   <= restart_d;
        end
    end

    assign kick_out      = kick_q;
    assign fault         = fault_q;
    assign restart_count = restart_q;

endmodule

// File: tb/tb_wdt_kick.sv
// Testbench for wdt_kick: hand-computed vector table, directed corner
// sequences, and randomized stimulus against a tick-counting reference model.
module tb_wdt_kick;

    localparam int HP = 5;
    localparam int AW = 20;
    localparam int HO = 3;

    logic       clk = 1'b0;
    logic       slow = 1'b0;
    logic       rst, en, al, wdt;
    logic       kick_out, fault;
    logic [7:0] restart_count;

    int n_vec = 0;
    int n_err = 0;

    wdt_kick #(
        .HALF_PERIOD (16'(HP)),
        .ALIVE_WINDOW(16'(AW)),
        .HOLDOFF     (16'(HO))
    ) dut (
        .clk          (clk),
        .reset        (rst),
        .clk_1kHz     (slow),
        .enable       (en),
        .alive        (al),
        .wdt_reset_in (wdt),
        .kick_out     (kick_out),
        .fault        (fault),
        .restart_count(restart_count)
    );

    // clk period 2; slow timebase period 20 (one tick per 10 clk)
    initial forever #1 clk = ~clk;
    initial forever #10 slow = ~slow;

    // Reference model: counts ticks since events, in terms of the behaviour rules.
    int m_mode = 0;            // 0 idle, 1 running, 2 starved, 3 holding off
    int m_since_alive = 0;
    int m_since_toggle = 0;
    int m_since_release = 0;
    int m_restarts = 0;
    bit m_kick = 0, m_fault = 0;
    bit m_k1 = 0, m_k2 = 0, m_wdt_seen = 0;
    bit m_tick, m_rise;

    always @(posedge clk) begin
        m_tick = m_k1 && !m_k2;
        m_rise = wdt && !m_wdt_seen;
        if (rst) begin
            m_mode = 0; m_since_alive = 0; m_since_toggle = 0; m_since_release = 0;
            m_restarts = 0; m_kick = 0; m_fault = 0;
            m_k1 = 0; m_k2 = 0; m_wdt_seen = 0;
        end else begin
            if (!en) begin
                m_mode = 0; m_kick = 0; m_fault = 0;
            end else if (m_mode != 0 && m_rise) begin
                m_mode = 3; m_kick = 0; m_fault = 0; m_since_release = 0;
                if (m_restarts < 255) m_restarts++;
            end else begin
                case (m_mode)
                    0: begin
                        m_mode = 1; m_since_alive = 0; m_since_toggle = 0;
                    end
                    1: begin
                        if (m_tick && !al && (m_since_alive + 1 == AW)) begin
                            m_mode = 2; m_fault = 1;
                        end else begin
                            if (m_tick) begin
                                m_since_toggle++;
                                if (m_since_toggle == HP) begin
                                    m_kick = !m_kick;
                                    m_since_toggle = 0;
                                end
                            end
                            if (al) m_since_alive = 0;
                            else if (m_tick) m_since_alive++;
                        end
                    end
                    2: begin
                        if (al) begin
                            m_mode = 1; m_fault = 0; m_since_alive = 0; m_since_toggle = 0;
                        end
                    end
                    default: begin
                        if (wdt) m_since_release = 0;
                        else if (m_tick) begin
                            m_since_release++;
                            if (m_since_release == HO) begin
                                m_mode = 1; m_since_alive = 0; m_since_toggle = 0;
                            end
                        end
                    end
                endcase
            end
            m_k2 = m_k1; m_k1 = slow; m_wdt_seen = wdt;
        end
    end

    task automatic check(input string name, input logic exp_k, input logic exp_f,
                         input logic [7:0] exp_rc, input bit verbose);
        n_vec++;
        if (kick_out !== exp_k || fault !== exp_f || restart_count !== exp_rc) begin
            n_err++;
            $display("FAIL %s t=%0t: got kick=%b fault=%b rc=%0d, want kick=%b fault=%b rc=%0d",
                     name, $time, kick_out, fault, restart_count, exp_k, exp_f, exp_rc);
        end else if (verbose) begin
            $display("ok   %s t=%0t: kick=%b fault=%b rc=%0d", name, $time,
                     kick_out, fault, restart_count);
        end
    endtask

    // Every cycle, compare against the reference model (sampled away from the active edge).
    bit model_on = 1'b0;
    always @(negedge clk) begin
        if (model_on) check("model", m_kick, m_fault, 8'(m_restarts), 1'b0);
    end

    typedef struct {
        logic       rst, en, al, wdt;
        int         n;
        logic       kick, fault;
        logic [7:0] rc;
    } vec_t;

    vec_t tbl[24];
    int   rate;

    initial begin
        rst = 1'b1; en = 1'b0; al = 1'b0; wdt = 1'b0;
        // Ticks take effect at posedges t = 20m+13; rows are timed from t=0.
        tbl[0]  = '{1, 0, 0, 0,   5, 0, 0, 8'd0};  // reset
        tbl[1]  = '{0, 0, 0, 1,   5, 0, 0, 8'd0};  // wdt in IDLE ignored
        tbl[2]  = '{0, 0, 0, 0,   5, 0, 0, 8'd0};
        tbl[3]  = '{0, 1, 0, 0,   1, 0, 0, 8'd0};  // enter RUN
        tbl[4]  = '{0, 1, 0, 0,  40, 0, 0, 8'd0};  // 4 ticks, no toggle yet
        tbl[5]  = '{0, 1, 1, 0,   1, 1, 0, 8'd0};  // 5th tick: first toggle
        tbl[6]  = '{0, 1, 0, 0, 199, 0, 0, 8'd0};  // 19 ticks without alive
        tbl[7]  = '{0, 1, 0, 0,   1, 0, 1, 8'd0};  // 20th tick: starve, kick frozen
        tbl[8]  = '{0, 1, 0, 0,  30, 0, 1, 8'd0};
        tbl[9]  = '{0, 1, 1, 0,   1, 0, 0, 8'd0};  // alive recovers
        tbl[10] = '{0, 1, 0, 0,  48, 0, 0, 8'd0};
        tbl[11] = '{0, 1, 0, 0,   1, 1, 0, 8'd0};  // toggle 5 ticks after recovery
        tbl[12] = '{0, 1, 0, 0, 149, 1, 0, 8'd0};
        tbl[13] = '{0, 1, 1, 0,   1, 0, 0, 8'd0};  // alive on window tick: no fault
        tbl[14] = '{0, 1, 0, 0, 199, 1, 0, 8'd0};  // alive count restarted from 0
        tbl[15] = '{0, 1, 0, 0,   1, 1, 1, 8'd0};  // starve with kick frozen high
        tbl[16] = '{0, 1, 1, 0,   1, 1, 0, 8'd0};
        tbl[17] = '{0, 1, 0, 1,   1, 0, 0, 8'd1};  // wdt rise
        tbl[18] = '{0, 1, 0, 1,  59, 0, 0, 8'd1};
        tbl[19] = '{0, 1, 0, 0,  78, 0, 0, 8'd1};  // holdoff then 4 run ticks
        tbl[20] = '{0, 1, 0, 0,   1, 1, 0, 8'd1};  // first toggle after holdoff
        tbl[21] = '{0, 0, 0, 0,   1, 0, 0, 8'd1};  // enable low
        tbl[22] = '{0, 0, 0, 1,   3, 0, 0, 8'd1};  // wdt pulse in IDLE
        tbl[23] = '{0, 0, 0, 0,   3, 0, 0, 8'd1};

        model_on = 1'b1;
        for (int i = 0; i < 24; i++) begin
            rst = tbl[i].rst; en = tbl[i].en; al = tbl[i].al; wdt = tbl[i].wdt;
            repeat (tbl[i].n) @(negedge clk);
            check($sformatf("vec%0d", i), tbl[i].kick, tbl[i].fault, tbl[i].rc, 1'b1);
        end

        // Saturation: 260 watchdog pulses on top of the one already counted.
        en = 1'b1; al = 1'b0; wdt = 1'b0;
        @(negedge clk);
        for (int p = 0; p < 260; p++) begin
            wdt = 1'b1; @(negedge clk);
            wdt = 1'b0; @(negedge clk);
            if (p == 9) check("rc_after_10", 1'b0, 1'b0, 8'd11, 1'b1);
        end
        check("rc_saturated", 1'b0, 1'b0, 8'd255, 1'b1);

        // Reset while holding off.
        wdt = 1'b1; @(negedge clk);
        rst = 1'b1; @(negedge clk);
        check("reset_in_holdoff", 1'b0, 1'b0, 8'd0, 1'b1);
        rst = 1'b0; wdt = 1'b0;

        // Randomized stimulus, checked every cycle against the model.
        rate = 30;
        for (int c = 0; c < 6000; c++) begin
            if (c % 500 == 0) rate = ($urandom_range(0, 1) == 0) ? 30 : 400;
            rst = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 299) == 0) en = ~en;
            if ($urandom_range(0, 149) == 0) wdt = ~wdt;
            al = ($urandom_range(0, rate - 1) == 0);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
